// File: rtl/nbit_seq_comparator.sv
// nbit_seq_comparator: multi-cycle magnitude comparator. Walks the operands one
// DIGIT-bit slice per clock from the most significant slice down and stops at
// the first slice that differs. Result is registered with a start/busy/done
// handshake.
// Optional feature: define CMP_SIGNED_EN to add the signed_mode input, which
// compares the top slice as two's complement (signed ordering of A and B).
module nbit_seq_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4,
  localparam int unsigned NDIG = WIDTH / DIGIT,
  localparam int unsigned CW   = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             agb,
  output logic             alb,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [0:0] {StIdle, StCmp} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              eq_q, eq_d, agb_q, agb_d, alb_q, alb_d;
  logic [CW-1:0]     cycles_q, cycles_d;
  logic [WIDTH-1:0]  a_sh, b_sh;
  logic [DIGIT-1:0]  sa, sb;
  logic              top_flip;

`ifdef CMP_SIGNED_EN
  logic sgn_q, sgn_d;

  // Signed mode captured alongside the operands.
  always_ff @(posedge clk) begin
    if (rst) sgn_q <= 1'b0;
    else     sgn_q <= sgn_d;
  end

  always_comb begin
    sgn_d = sgn_q;
    if (state_q == StIdle && start) sgn_d = signed_mode;
  end

  assign top_flip = sgn_q && (idx_q == IW'(NDIG - 1));
`else
  assign top_flip = 1'b0;
`endif

  // Current slice of each operand; flipping the sign bit of the top slice turns
  // two's-complement order into plain unsigned order.
  always_comb begin
    a_sh = a_q >> (DIGIT * idx_q);
    b_sh = b_q >> (DIGIT * idx_q);
    sa = a_sh[DIGIT-1:0];
    sb = b_sh[DIGIT-1:0];
    sa[DIGIT-1] = sa[DIGIT-1] ^ top_flip;
    sb[DIGIT-1] = sb[DIGIT-1] ^ top_flip;
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      agb_q    <= 1'b0;
      alb_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      eq_q     <= eq_d;
      agb_q    <= agb_d;
      alb_q    <= alb_d;
      cycles_q <= cycles_d;
    end
  end

  // Next-state: accept a start in idle, then examine one slice per cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    eq_d     = eq_q;
    agb_d    = agb_q;
    alb_d    = alb_q;
    cycles_d = cycles_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          idx_d    = IW'(NDIG - 1);
          eq_d     = 1'b0;
          agb_d    = 1'b0;
          alb_d    = 1'b0;
          cycles_d = '0;
          busy_d   = 1'b1;
          state_d  = StCmp;
        end
      end
      StCmp: begin
        cycles_d = cycles_q + CW'(1);
        if (sa != sb) begin
          agb_d   = (sa > sb);
          alb_d   = (sa < sb);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign eq     = eq_q;
  assign agb    = agb_q;
  assign alb    = alb_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_nbit_seq_comparator.sv
// Bench for nbit_seq_comparator (WIDTH=16, DIGIT=4, unsigned build).
module tb_nbit_seq_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  a = '0, b = '0;
  logic              busy, done, eq, agb, alb;
  logic [2:0]        cycles;

  int errs = 0;
  int checks = 0;

  nbit_seq_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .eq     (eq),
    .agb    (agb),
    .alb    (alb),
    .cycles (cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slices examined: count from the top down, stopping at the first difference.
  function automatic int slices_examined(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int k = 0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      k++;
      if (((x >> (DIGIT * i)) & 16'hF) != ((y >> (DIGIT * i)) & 16'hF)) break;
    end
    return k;
  endfunction

  // Transaction-level model: a start seen while idle schedules the result k edges later.
  logic m_busy = 0, m_done = 0, m_eq = 0, m_agb = 0, m_alb = 0;
  int   m_cycles = 0, m_left = 0;
  logic p_eq, p_agb, p_alb;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_eq = 0; m_agb = 0; m_alb = 0; m_cycles = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        m_cycles++;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_eq = p_eq; m_agb = p_agb; m_alb = p_alb;
        end
      end else if (start) begin
        p_eq = (a == b); p_agb = (a > b); p_alb = (a < b);
        m_left = slices_examined(a, b);
        m_busy = 1; m_eq = 0; m_agb = 0; m_alb = 0; m_cycles = 0;
      end
    end
  end

  // Compare every cycle, just after the edge.
  always begin
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("eq", 32'(eq), 32'(m_eq));
    chk("agb", 32'(agb), 32'(m_agb));
    chk("alb", 32'(alb), 32'(m_alb));
    chk("cycles", 32'(cycles), 32'(m_cycles));
  end

  // Pulse start and return the number of edges from acceptance to done.
  task automatic run(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, output int n);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic expect_result(input string name, input int n, input int k,
                               input logic e, input logic g, input logic l);
    chk({name, "_lat"}, 32'(n), 32'(k));
    chk({name, "_eq"}, 32'(eq), 32'(e));
    chk({name, "_agb"}, 32'(agb), 32'(g));
    chk({name, "_alb"}, 32'(alb), 32'(l));
    chk({name, "_cyc"}, 32'(cycles), 32'(k));
  endtask

  int n;
  int dones;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_flags", 32'({eq, agb, alb, done}), 32'd0);
    chk("idle_cycles", 32'(cycles), 32'd0);

    // Literal expectations that also pin the model's slice counting.
    chk("model_k_eq", 32'(slices_examined(16'h1234, 16'h1234)), 32'd4);
    chk("model_k_top", 32'(slices_examined(16'h8000, 16'h7FFF)), 32'd1);
    chk("model_k_mid", 32'(slices_examined(16'h12A4, 16'h12B4)), 32'd3);

    run(16'h1234, 16'h1234, n); expect_result("equal", n, 4, 1, 0, 0);
    run(16'h8000, 16'h7FFF, n); expect_result("top", n, 1, 0, 1, 0);
    run(16'h12A4, 16'h12B4, n); expect_result("mid_lt", n, 3, 0, 0, 1);
    run(16'h12B4, 16'h12A4, n); expect_result("mid_gt", n, 3, 0, 1, 0);
    run(16'h0000, 16'h0001, n); expect_result("last", n, 4, 0, 0, 1);

    // Start held high while operands churn; second start taken in the done cycle.
    @(negedge clk);
    a = 16'h00F0; b = 16'h00E0; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (n < 20) begin
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    expect_result("held", n, 3, 0, 1, 0);
    a = 16'h5555; b = 16'h5556;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_clear", 32'({eq, agb, alb}), 32'd0);
    n = 1;
    while (n < 20) begin
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    chk("b2b_lat", 32'(n), 32'd5);
    chk("b2b_alb", 32'(alb), 32'd1);
    chk("b2b_cyc", 32'(cycles), 32'd4);

    // Abort an equal-operand compare two cycles in.
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pre_cyc", 32'(cycles), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_flags", 32'({eq, agb, alb}), 32'd0);
    chk("abort_cyc", 32'(cycles), 32'd0);
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_idle", 32'({busy, eq, agb, alb, cycles}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
